// File: rtl/cpu4_wbck.sv
// Purpose : writeback arbiter; merges ALU results and buffered LSU load returns onto one regfile write port.
// Latency : ALU accept -> rd_wen next cycle; LSU accept -> FIFO -> rd_wen two cycles later at the earliest.
// Backpres: alu_wbck_ready = lsu_wbck_ready = ~fifo_full; a full FIFO always drains its head first.
//
// Ports:
//   clk, rst                    core clock, asynchronous active-high reset
//   alu_wbck_valid/ready/idx/data   ALU result handshake
//   lsu_wbck_valid/ready/idx/data   load return handshake (enqueued into FIFO)
//   lsu_issue_valid/idx         marks the destination of an issued load busy
//   sb_busy                     per-register pending-load bits (bit 0 never set)
//   rd_wen/rd_idx/rd_data       registered regfile write port
// Optional feature (macro CPU4_WBCK_BYPASS_EN): rs1_idx/rs2_idx inputs and
//   rsX_fwd_hit/rsX_fwd_data outputs forwarding the current rd write.
module cpu4_wbck #(
  parameter int XLEN      = 32,
  parameter int RFIDX_W   = 5,
  parameter int LSU_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_wbck_valid,
  output logic                    alu_wbck_ready,
  input  logic [RFIDX_W-1:0]      alu_wbck_idx,
  input  logic [XLEN-1:0]         alu_wbck_data,
  input  logic                    lsu_wbck_valid,
  output logic                    lsu_wbck_ready,
  input  logic [RFIDX_W-1:0]      lsu_wbck_idx,
  input  logic [XLEN-1:0]         lsu_wbck_data,
  input  logic                    lsu_issue_valid,
  input  logic [RFIDX_W-1:0]      lsu_issue_idx,
`ifdef CPU4_WBCK_BYPASS_EN
  input  logic [RFIDX_W-1:0]      rs1_idx,
  input  logic [RFIDX_W-1:0]      rs2_idx,
  output logic                    rs1_fwd_hit,
  output logic                    rs2_fwd_hit,
  output logic [XLEN-1:0]         rs1_fwd_data,
  output logic [XLEN-1:0]         rs2_fwd_data,
`endif
  output logic [(1<<RFIDX_W)-1:0] sb_busy,
  output logic                    rd_wen,
  output logic [RFIDX_W-1:0]      rd_idx,
  output logic [XLEN-1:0]         rd_data
);

  localparam int PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << RFIDX_W;

  // LSU return FIFO storage; only pointers and count carry reset state.
  logic [RFIDX_W-1:0] fifo_idx  [LSU_DEPTH];
  logic [XLEN-1:0]    fifo_data [LSU_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  logic fifo_full, fifo_empty;
  logic enq, deq, sel_alu;
  logic [RFIDX_W-1:0] sel_idx;
  logic [XLEN-1:0]    sel_data;
  logic [RFIDX_W-1:0] head_idx;
  logic [NREG-1:0]    sb_next;

  assign fifo_full  = (count == CNT_W'(LSU_DEPTH));
  assign fifo_empty = (count == '0);
  assign head_idx   = fifo_idx[rd_ptr];

  assign alu_wbck_ready = ~fifo_full;
  assign lsu_wbck_ready = ~fifo_full;

  // No enqueue while full, even if the head leaves this cycle.
  assign enq     = lsu_wbck_valid & ~fifo_full;
  // Full FIFO wins so ALU traffic cannot starve load returns forever.
  assign deq     = fifo_full | (~alu_wbck_valid & ~fifo_empty);
  assign sel_alu = alu_wbck_valid & ~fifo_full;

  always_comb begin
    sel_idx  = head_idx;
    sel_data = fifo_data[rd_ptr];
    if (sel_alu) begin
      sel_idx  = alu_wbck_idx;
      sel_data = alu_wbck_data;
    end
  end

  // Clear first, then set: a same-cycle issue to the dequeued register stays busy.
  always_comb begin
    sb_next = sb_busy;
    if (deq)             sb_next[head_idx]      = 1'b0;
    if (lsu_issue_valid) sb_next[lsu_issue_idx] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_idx[wr_ptr]  <= lsu_wbck_idx;
      fifo_data[wr_ptr] <= lsu_wbck_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      sb_busy <= '0;
      rd_wen  <= 1'b0;
      rd_idx  <= '0;
      rd_data <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      sb_busy <= sb_next;
      if (sel_alu | deq) begin
        // idx 0 is consumed like any write but never enables the regfile.
        rd_wen  <= (sel_idx != '0);
        rd_idx  <= sel_idx;
        rd_data <= sel_data;
      end else begin
        rd_wen  <= 1'b0;
      end
    end
  end

`ifdef CPU4_WBCK_BYPASS_EN
  assign rs1_fwd_hit  = rd_wen & (rd_idx == rs1_idx) & (rs1_idx != '0);
  assign rs2_fwd_hit  = rd_wen & (rd_idx == rs2_idx) & (rs2_idx != '0);
  assign rs1_fwd_data = rd_data;
  assign rs2_fwd_data = rd_data;
`endif

endmodule

// File: tb/tb_cpu4_wbck.sv
module tb_cpu4_wbck;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wbck_valid = 1'b0, alu_wbck_ready;
  logic [4:0]  alu_wbck_idx = '0;
  logic [31:0] alu_wbck_data = '0;
  logic        lsu_wbck_valid = 1'b0, lsu_wbck_ready;
  logic [4:0]  lsu_wbck_idx = '0;
  logic [31:0] lsu_wbck_data = '0;
  logic        lsu_issue_valid = 1'b0;
  logic [4:0]  lsu_issue_idx = '0;
  logic [31:0] sb_busy;
  logic        rd_wen;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;
`ifdef CPU4_WBCK_BYPASS_EN
  logic [4:0]  rs1_idx = '0, rs2_idx = '0;
  logic        rs1_fwd_hit, rs2_fwd_hit;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [36:0] alu_q[$];
  logic [36:0] lsu_q[$];

  cpu4_wbck dut (
    .clk(clk), .rst(rst),
    .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
    .alu_wbck_idx(alu_wbck_idx), .alu_wbck_data(alu_wbck_data),
    .lsu_wbck_valid(lsu_wbck_valid), .lsu_wbck_ready(lsu_wbck_ready),
    .lsu_wbck_idx(lsu_wbck_idx), .lsu_wbck_data(lsu_wbck_data),
    .lsu_issue_valid(lsu_issue_valid), .lsu_issue_idx(lsu_issue_idx),
`ifdef CPU4_WBCK_BYPASS_EN
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
    .sb_busy(sb_busy), .rd_wen(rd_wen), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Every regfile write must match the oldest pending write of one stream.
  always @(negedge clk) begin
    if (mon_en && !rst && rd_wen === 1'b1) begin
      checks++;
      if (alu_q.size() > 0 && alu_q[0] === {rd_idx, rd_data}) begin
        void'(alu_q.pop_front());
      end else if (lsu_q.size() > 0 && lsu_q[0] === {rd_idx, rd_data}) begin
        void'(lsu_q.pop_front());
      end else begin
        failures++;
        $display("FAIL rd_write: got idx=%0d data=%h, not the next expected ALU/LSU write", rd_idx, rd_data);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (rd_wen !== 1'b0)   begin failures++; $display("FAIL reset_rd_wen got %b want 0", rd_wen); end
    checks++; if (rd_idx !== 5'd0)   begin failures++; $display("FAIL reset_rd_idx got %0d want 0", rd_idx); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    checks++; if (sb_busy !== 32'd0) begin failures++; $display("FAIL reset_sb_busy got %h want 0", sb_busy); end
    checks++; if (lsu_wbck_ready !== 1'b1) begin failures++; $display("FAIL reset_lsu_ready got %b want 1", lsu_wbck_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    // Fill the FIFO to two entries while the ALU holds the write port.
    alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd1; alu_wbck_data = 32'h11;
    lsu_wbck_valid = 1'b1; lsu_wbck_idx = 5'd4; lsu_wbck_data = 32'h44;
    lsu_issue_valid = 1'b1; lsu_issue_idx = 5'd4;
    @(posedge clk); #1;
    lsu_wbck_idx = 5'd6; lsu_wbck_data = 32'h66; lsu_issue_idx = 5'd6;
    @(posedge clk); #1;
    alu_wbck_valid = 1'b0; lsu_wbck_valid = 1'b0; lsu_issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (lsu_wbck_ready !== 1'b0) begin failures++; $display("FAIL midop_full_lsu_ready got %b want 0", lsu_wbck_ready); end
    checks++; if (sb_busy !== 32'h50) begin failures++; $display("FAIL midop_sb_busy got %h want 00000050", sb_busy); end
    rst = 1'b1; #1;
    checks++; if (rd_wen !== 1'b0)   begin failures++; $display("FAIL midrst_rd_wen got %b want 0", rd_wen); end
    checks++; if (rd_idx !== 5'd0)   begin failures++; $display("FAIL midrst_rd_idx got %0d want 0", rd_idx); end
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL midrst_rd_data got %h want 0", rd_data); end
    checks++; if (sb_busy !== 32'd0) begin failures++; $display("FAIL midrst_sb_busy got %h want 0", sb_busy); end
    checks++; if (lsu_wbck_ready !== 1'b1) begin failures++; $display("FAIL midrst_lsu_ready got %b want 1", lsu_wbck_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (rd_wen !== 1'b0) begin failures++; $display("FAIL postrst_fifo_empty rd_wen got %b want 0", rd_wen); end
    end
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd5; alu_wbck_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (alu_wbck_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got %b want 1", alu_wbck_ready); end
    alu_q.push_back({5'd5, 32'hDEADBEEF});
    @(posedge clk); #1;
    alu_wbck_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_wen !== 1'b1) begin failures++; $display("FAIL alu_lat_wen got %b want 1", rd_wen); end
    checks++; if (rd_idx !== 5'd5) begin failures++; $display("FAIL alu_lat_idx got %0d want 5", rd_idx); end
    checks++; if (rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_lat_data got %h want deadbeef", rd_data); end
    @(negedge clk);
    checks++; if (rd_wen !== 1'b0) begin failures++; $display("FAIL alu_idle_wen got %b want 0", rd_wen); end
    @(posedge clk); #1;
  endtask

  task automatic test_scoreboard();
    lsu_issue_valid = 1'b1; lsu_issue_idx = 5'd7;
    @(posedge clk); #1;
    lsu_issue_valid = 1'b0;
    @(posedge clk); #1;
    lsu_wbck_valid = 1'b1; lsu_wbck_idx = 5'd7; lsu_wbck_data = 32'h12345678;
    @(negedge clk);
    checks++; if (sb_busy[7] !== 1'b1) begin failures++; $display("FAIL sb_set got %b want 1", sb_busy[7]); end
    checks++; if (lsu_wbck_ready !== 1'b1) begin failures++; $display("FAIL sb_lsu_ready got %b want 1", lsu_wbck_ready); end
    lsu_q.push_back({5'd7, 32'h12345678});
    @(posedge clk); #1;
    lsu_wbck_valid = 1'b0;
    @(negedge clk);
    checks++; if (sb_busy[7] !== 1'b1) begin failures++; $display("FAIL sb_hold_n1 got %b want 1", sb_busy[7]); end
    checks++; if (rd_wen !== 1'b0) begin failures++; $display("FAIL lsu_lat_n1_wen got %b want 0", rd_wen); end
    @(negedge clk);
    checks++; if (rd_wen !== 1'b1 || rd_idx !== 5'd7) begin failures++; $display("FAIL lsu_lat_n2 got wen=%b idx=%0d want wen=1 idx=7", rd_wen, rd_idx); end
    checks++; if (sb_busy[7] !== 1'b0) begin failures++; $display("FAIL sb_clear got %b want 0", sb_busy[7]); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int j = 0;
    for (int c = 0; c < 10; c++) begin
      alu_wbck_valid = (k < 6);
      alu_wbck_idx   = 5'(10 + k);
      alu_wbck_data  = 32'hA0000000 + 32'(k);
      lsu_wbck_valid = (j < 2);
      lsu_wbck_idx   = 5'(20 + j);
      lsu_wbck_data  = 32'hB0000000 + 32'(j);
      @(negedge clk);
      if (c == 2) begin
        checks++; if (alu_wbck_ready !== 1'b0) begin failures++; $display("FAIL full_alu_ready got %b want 0", alu_wbck_ready); end
        checks++; if (lsu_wbck_ready !== 1'b0) begin failures++; $display("FAIL full_lsu_ready got %b want 0", lsu_wbck_ready); end
      end
      if (c == 3) begin
        checks++; if (rd_wen !== 1'b1 || rd_idx !== 5'd20 || rd_data !== 32'hB0000000) begin
          failures++; $display("FAIL full_head_first got wen=%b idx=%0d data=%h want 1/20/b0000000", rd_wen, rd_idx, rd_data); end
      end
      if (c == 4) begin
        checks++; if (rd_wen !== 1'b1 || rd_idx !== 5'd12 || rd_data !== 32'hA0000002) begin
          failures++; $display("FAIL alu_resume got wen=%b idx=%0d data=%h want 1/12/a0000002", rd_wen, rd_idx, rd_data); end
      end
      if (alu_wbck_valid && alu_wbck_ready) begin
        alu_q.push_back({alu_wbck_idx, alu_wbck_data}); k++;
      end
      if (lsu_wbck_valid && lsu_wbck_ready) begin
        lsu_q.push_back({lsu_wbck_idx, lsu_wbck_data}); j++;
      end
      @(posedge clk); #1;
    end
    alu_wbck_valid = 1'b0; lsu_wbck_valid = 1'b0;
    checks++; if (k !== 6 || j !== 2) begin failures++; $display("FAIL b2b_accepts got alu=%0d lsu=%0d want 6/2", k, j); end
  endtask

  task automatic test_idx0();
    alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd0; alu_wbck_data = 32'hFFFFFFFF;
    lsu_issue_valid = 1'b1; lsu_issue_idx = 5'd0;
    @(negedge clk);
    checks++; if (alu_wbck_ready !== 1'b1) begin failures++; $display("FAIL idx0_alu_ready got %b want 1", alu_wbck_ready); end
    @(posedge clk); #1;
    alu_wbck_valid = 1'b0; lsu_issue_valid = 1'b0;
    lsu_wbck_valid = 1'b1; lsu_wbck_idx = 5'd0; lsu_wbck_data = 32'h0BAD;
    @(negedge clk);
    checks++; if (rd_wen !== 1'b0) begin failures++; $display("FAIL idx0_alu_wen got %b want 0", rd_wen); end
    checks++; if (sb_busy !== 32'd0) begin failures++; $display("FAIL sb_bit0 got %h want 0", sb_busy); end
    @(posedge clk); #1;
    lsu_wbck_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (rd_wen !== 1'b0) begin failures++; $display("FAIL idx0_lsu_wen got %b want 0", rd_wen); end
    end
    checks++; if (lsu_wbck_ready !== 1'b1) begin failures++; $display("FAIL idx0_drained_ready got %b want 1", lsu_wbck_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_set_wins();
    lsu_issue_valid = 1'b1; lsu_issue_idx = 5'd9;
    @(posedge clk); #1;
    lsu_issue_valid = 1'b0;
    lsu_wbck_valid = 1'b1; lsu_wbck_idx = 5'd9; lsu_wbck_data = 32'h99;
    @(negedge clk);
    lsu_q.push_back({5'd9, 32'h99});
    @(posedge clk); #1;
    lsu_wbck_valid = 1'b0;
    lsu_issue_valid = 1'b1; lsu_issue_idx = 5'd9;  // same cycle as dequeue of idx 9
    @(posedge clk); #1;
    lsu_issue_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_wen !== 1'b1 || rd_idx !== 5'd9) begin failures++; $display("FAIL setwins_write got wen=%b idx=%0d want 1/9", rd_wen, rd_idx); end
    checks++; if (sb_busy[9] !== 1'b1) begin failures++; $display("FAIL setwins_busy got %b want 1", sb_busy[9]); end
    @(posedge clk); #1;
    lsu_wbck_valid = 1'b1; lsu_wbck_data = 32'h9A;
    @(negedge clk);
    lsu_q.push_back({5'd9, 32'h9A});
    @(posedge clk); #1;
    lsu_wbck_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sb_busy !== 32'd0) begin failures++; $display("FAIL setwins_clear got %h want 0", sb_busy); end
    @(posedge clk); #1;
  endtask

`ifdef CPU4_WBCK_BYPASS_EN
  task automatic test_bypass();
    alu_wbck_valid = 1'b1; alu_wbck_idx = 5'd3; alu_wbck_data = 32'hA5A5A5A5;
    @(negedge clk);
    alu_q.push_back({5'd3, 32'hA5A5A5A5});
    @(posedge clk); #1;
    alu_wbck_valid = 1'b0;
    rs1_idx = 5'd3; rs2_idx = 5'd0;
    #1;
    checks++; if (rs1_fwd_hit !== 1'b1) begin failures++; $display("FAIL byp_rs1_hit got %b want 1", rs1_fwd_hit); end
    checks++; if (rs1_fwd_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL byp_rs1_data got %h want a5a5a5a5", rs1_fwd_data); end
    checks++; if (rs2_fwd_hit !== 1'b0) begin failures++; $display("FAIL byp_rs2_hit got %b want 0", rs2_fwd_hit); end
    @(posedge clk); #1;
    checks++; if (rs1_fwd_hit !== 1'b0) begin failures++; $display("FAIL byp_idle_hit got %b want 0", rs1_fwd_hit); end
  endtask
`endif

  task automatic test_drain();
    for (int i = 0; i < 50; i++) begin
      if (alu_q.size() == 0 && lsu_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (alu_q.size() + lsu_q.size() !== 0) begin
      failures++; $display("FAIL drain pending alu=%0d lsu=%0d want 0/0", alu_q.size(), lsu_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_scoreboard();
    test_back_to_back();
    test_drain();
    test_idx0();
    test_set_wins();
`ifdef CPU4_WBCK_BYPASS_EN
    test_bypass();
`endif
    test_drain();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
